i2c_enable_seq: RTL and testbench

I2C_ENABLE_SEQ -- requirements
Module: i2c_enable_seq

---
 rtl/i2c_enable_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_enable_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_enable_seq.sv
// i2c_enable_seq: drives an APB master that writes IC_ENABLE, then polls
// IC_ENABLE_STATUS until bit0 matches the requested value. The sequence can
// time out, be aborted or fail on a slave error, and it reports the outcome
// with a one-cycle done pulse and a held status code.
module i2c_enable_seq #(
  parameter int unsigned           ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]     ENABLE_ADDR = 8'h6C,
  parameter logic [ADDR_W-1:0]     STATUS_ADDR = 8'h9C,
  parameter int unsigned           POLL_MAX    = 16,
  parameter int unsigned           POLL_GAP    = 4
) (
  input  logic              apb_clk,
  input  logic              apb_rstn,
  input  logic              req_valid,
  input  logic              req_enable,
  output logic              req_ready,
  input  logic              abort,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    GAP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ABORTED = 2'b10,
    ST_SLVERR  = 2'b11
  } result_e;

  // Last GAP count value; unused when POLL_GAP is 0 since GAP is skipped.
  localparam logic [7:0]  GAP_LAST   = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

  state_e             state_q, state_d;
  logic               tgt_q, tgt_d;
  logic [15:0]        poll_cnt_q, poll_cnt_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic               abort_pend_q, abort_pend_d;
  logic [1:0]         status_q, status_d;
  logic               done_q, done_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;

  logic               abort_now;
  logic [15:0]        poll_inc;
  logic               unused_prdata;

  // Only bit0 of the status register matters.
  assign unused_prdata = ^prdata[31:1];

  // An abort seen in this cycle counts the same as one latched earlier.
  assign abort_now = abort_pend_q | abort;

  // Saturating increment keeps the poll counter from wrapping.
  assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

  // Next-state and result logic of the enable/poll sequence.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d      = state_q;
    tgt_d        = tgt_q;
    poll_cnt_d   = poll_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;
    status_d     = status_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d        = req_enable;
          poll_cnt_d   = 16'd0;
          gap_cnt_d    = 8'd0;
          abort_pend_d = 1'b0;
          state_d      = WR_SETUP;
        end
      end

      WR_SETUP: begin
        abort_pend_d = abort_now;
        state_d      = WR_ACCESS;
      end

      WR_ACCESS: begin
        abort_pend_d = abort_now;
        if (pready) begin
          if (pslverr) begin
            status_d = ST_SLVERR;
            state_d  = DONE;
          end else if (abort_now) begin
            status_d = ST_ABORTED;
            state_d  = DONE;
          end else begin
            state_d  = RD_SETUP;
          end
        end
      end

      RD_SETUP: begin
        abort_pend_d = abort_now;
        state_d      = RD_ACCESS;
      end

      RD_ACCESS: begin
        abort_pend_d = abort_now;
        if (pready) begin
          poll_cnt_d = poll_inc;
          if (pslverr) begin
            status_d = ST_SLVERR;
            state_d  = DONE;
          end else if (abort_now) begin
            status_d = ST_ABORTED;
            state_d  = DONE;
          end else if (prdata[0] == tgt_q) begin
            // A match on the last permitted read still counts as success.
            status_d = ST_OK;
            state_d  = DONE;
          end else if (poll_inc >= POLL_LIMIT) begin
            status_d = ST_TIMEOUT;
            state_d  = DONE;
          end else if (POLL_GAP == 0) begin
            state_d  = RD_SETUP;
          end else begin
            gap_cnt_d = 8'd0;
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = DONE;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d  = RD_SETUP;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end

      DONE: begin
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // APB and handshake outputs, decoded from the upcoming state so they are
  // registered and line up with the state they belong to.
  always_comb begin
    psel_d    = (state_d == WR_SETUP) || (state_d == WR_ACCESS) ||
                (state_d == RD_SETUP) || (state_d == RD_ACCESS);
    penable_d = (state_d == WR_ACCESS) || (state_d == RD_ACCESS);
    done_d    = (state_d == DONE);
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;

    if (state_d == WR_SETUP) begin
      paddr_d  = ENABLE_ADDR;
      pwrite_d = 1'b1;
      pwdata_d = {31'b0, tgt_d};
    end else if (state_d == RD_SETUP) begin
      paddr_d  = STATUS_ADDR;
      pwrite_d = 1'b0;
    end
  end

  // State and output registers; reset drops psel at once, mid-transfer too.
  always_ff @(posedge apb_clk or posedge apb_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (apb_rstn) begin
      state_q      <= IDLE;
      tgt_q        <= 1'b0;
      poll_cnt_q   <= 16'd0;
      gap_cnt_q    <= 8'd0;
      abort_pend_q <= 1'b0;
      status_q     <= ST_OK;
      done_q       <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      poll_cnt_q   <= poll_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_pend_q <= abort_pend_d;
      status_q     <= status_d;
      done_q       <= done_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  // Ready only while idle and out of reset, so it rises the cycle reset ends.
  assign req_ready = (state_q == IDLE) && !apb_rstn;
  assign done      = done_q;
  assign status    = status_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_i2c_enable_seq.sv
// Directed bench for i2c_enable_seq: a small APB slave with configurable
// wait states, error response and read data, plus a transfer logger.
module tb_i2c_enable_seq;

  logic        apb_clk   = 1'b0;
  logic        apb_rstn  = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_enable = 1'b0;
  logic        req_ready;
  logic        abort     = 1'b0;
  logic        done;
  logic [1:0]  status;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata    = 32'd0;
  logic        pready    = 1'b0;
  logic        pslverr   = 1'b0;

  always #5 apb_clk = ~apb_clk;

  i2c_enable_seq dut (
    .apb_clk    (apb_clk),
    .apb_rstn   (apb_rstn),
    .req_valid  (req_valid),
    .req_enable (req_enable),
    .req_ready  (req_ready),
    .abort      (abort),
    .done       (done),
    .status     (status),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // Slave configuration.
  int   wait_cfg   = 0;
  logic wr_err     = 1'b0;
  logic rd_default = 1'b0;
  logic rd_q[$];
  int   wait_cnt   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] data;
    int          acc;
    int          gap;
  } txn_t;

  txn_t        log_q[$];
  int          n_done   = 0;
  int          idle_run = 0;
  int          pend_gap = 0;
  int          acc_run  = 0;
  logic        unstable = 1'b0;
  logic [7:0]  s_addr;
  logic        s_wr;
  logic [31:0] s_data;

  int n_vec = 0;
  int n_err = 0;

  // Slave response, driven on the falling edge.
  always @(negedge apb_clk) begin
    if (psel && penable) begin
      if (wait_cnt >= wait_cfg) begin
        pready  = 1'b1;
        pslverr = pwrite ? wr_err : 1'b0;
        prdata  = {31'b0, (rd_q.size() > 0) ? rd_q[0] : rd_default};
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        wait_cnt++;
      end
    end else begin
      pready   = 1'b0;
      pslverr  = 1'b0;
      wait_cnt = 0;
    end
  end

  // Transfer and done-pulse logger, sampling pre-edge values.
  always @(posedge apb_clk) begin
    if (done) n_done++;
    if (!psel) begin
      idle_run++;
    end else if (!penable) begin
      pend_gap = idle_run;
      idle_run = 0;
      acc_run  = 0;
      s_addr   = paddr;
      s_wr     = pwrite;
      s_data   = pwdata;
    end else begin
      acc_run++;
      if (paddr !== s_addr || pwrite !== s_wr || pwdata !== s_data) unstable = 1'b1;
      if (pready) begin
        log_q.push_back('{paddr, pwrite, pwdata, acc_run, pend_gap});
        if (!pwrite && rd_q.size() > 0) void'(rd_q.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t get_txn(input int i);
    txn_t t;
    t = '{8'hEE, 1'bx, 32'hDEAD_BEEF, -1, -1};
    if (i < log_q.size()) t = log_q[i];
    return t;
  endfunction

  task automatic tick();
    @(posedge apb_clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    n_done   = 0;
    idle_run = 0;
    unstable = 1'b0;
  endtask

  task automatic start_req(input logic en);
    req_valid  = 1'b1;
    req_enable = en;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    txn_t t;

    // Reset state.
    #2 apb_rstn = 1'b1;
    tick();
    tick();
    chk("rst_psel",      32'(psel),      32'd0);
    chk("rst_penable",   32'(penable),   32'd0);
    chk("rst_pwrite",    32'(pwrite),    32'd0);
    chk("rst_paddr",     32'(paddr),     32'd0);
    chk("rst_pwdata",    pwdata,         32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_status",    32'(status),    32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    apb_rstn = 1'b0;
    #1;
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    tick();

    // Enable, status reads 0,0,1.
    clear_log();
    rd_q = '{1'b0, 1'b0, 1'b1};
    start_req(1'b1);
    wait_done("en", 200);
    chk("en_status", 32'(status), 32'd0);
    tick();
    chk("en_done_width", 32'(done), 32'd0);
    chk("en_done_cnt",   n_done, 32'd1);
    chk("en_ready_back", 32'(req_ready), 32'd1);
    chk("en_txn_cnt",    log_q.size(), 32'd4);
    t = get_txn(0);
    chk("en_wr_addr", 32'(t.addr), 32'h6C);
    chk("en_wr_flag", 32'(t.wr),   32'd1);
    chk("en_wr_data", t.data,      32'h1);
    t = get_txn(1);
    chk("en_rd1_addr", 32'(t.addr), 32'h9C);
    chk("en_rd1_flag", 32'(t.wr),   32'd0);
    t = get_txn(2);
    chk("en_rd2_gap", t.gap, 32'd4);
    t = get_txn(3);
    chk("en_rd3_addr", 32'(t.addr), 32'h9C);
    chk("en_rd3_gap", t.gap, 32'd4);

    // Disable with status stuck at 1: timeout after 16 reads.
    clear_log();
    rd_default = 1'b1;
    start_req(1'b0);
    wait_done("to", 400);
    chk("to_status", 32'(status), 32'd1);
    tick();
    chk("to_txn_cnt", log_q.size(), 32'd17);
    t = get_txn(0);
    chk("to_wr_data", t.data, 32'h0);
    chk("to_done_cnt", n_done, 32'd1);

    // Match on the final allowed read reports success.
    clear_log();
    rd_q.delete();
    for (int i = 0; i < 15; i++) rd_q.push_back(1'b1);
    rd_q.push_back(1'b0);
    start_req(1'b0);
    wait_done("last", 400);
    chk("last_status", 32'(status), 32'd0);
    tick();
    chk("last_txn_cnt", log_q.size(), 32'd17);

    // Slave error on the write with 3 wait states.
    clear_log();
    rd_q.delete();
    wait_cfg = 3;
    wr_err   = 1'b1;
    start_req(1'b1);
    wait_done("err", 100);
    chk("err_status", 32'(status), 32'd3);
    tick();
    chk("err_txn_cnt", log_q.size(), 32'd1);
    t = get_txn(0);
    chk("err_acc_cycles", t.acc, 32'd4);
    chk("err_stable", 32'(unstable), 32'd0);
    wait_cfg = 0;
    wr_err   = 1'b0;

    // Abort in the RD_SETUP cycle with a delayed matching read.
    clear_log();
    wait_cfg   = 2;
    rd_default = 1'b0;
    rd_q = '{1'b1};
    start_req(1'b1);
    for (int i = 0; i < 50 && !(psel && !penable && !pwrite); i++) tick();
    chk("ab_rd_setup_seen", 32'(psel && !penable && !pwrite), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("ab", 100);
    chk("ab_status", 32'(status), 32'd2);
    tick();
    chk("ab_txn_cnt", log_q.size(), 32'd2);
    t = get_txn(1);
    chk("ab_rd_addr", 32'(t.addr), 32'h9C);
    wait_cfg = 0;

    // Abort during GAP ends the sequence on the next edge.
    clear_log();
    rd_q.delete();
    start_req(1'b1);
    for (int i = 0; i < 50 && !(!psel && log_q.size() == 2); i++) tick();
    chk("gab_in_gap", 32'(!psel && log_q.size() == 2), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("gab_done",   32'(done),   32'd1);
    chk("gab_status", 32'(status), 32'd2);
    tick();
    chk("gab_txn_cnt", log_q.size(), 32'd2);

    // Reset during WR_ACCESS, then a normal request.
    clear_log();
    rd_default = 1'b1;
    start_req(1'b1);
    for (int i = 0; i < 20 && !(psel && penable && pwrite); i++) tick();
    chk("rst_wr_access_seen", 32'(psel && penable && pwrite), 32'd1);
    apb_rstn = 1'b1;
    #1;
    chk("midrst_psel",    32'(psel),    32'd0);
    chk("midrst_penable", 32'(penable), 32'd0);
    tick();
    apb_rstn = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    clear_log();
    start_req(1'b1);
    wait_done("post", 100);
    chk("post_status", 32'(status), 32'd0);
    tick();
    chk("post_txn_cnt", log_q.size(), 32'd2);

    // Abort in IDLE is ignored; req_valid during GAP is ignored.
    clear_log();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rd_default = 1'b0;
    rd_q = '{1'b0, 1'b1};
    start_req(1'b1);
    for (int i = 0; i < 50 && !(!psel && log_q.size() == 2); i++) tick();
    chk("rv_in_gap", 32'(!psel && log_q.size() == 2), 32'd1);
    req_valid  = 1'b1;
    req_enable = 1'b0;
    tick();
    req_valid  = 1'b0;
    wait_done("rv", 100);
    chk("rv_status", 32'(status), 32'd0);
    repeat (20) tick();
    chk("rv_done_cnt", n_done, 32'd1);
    chk("rv_txn_cnt", log_q.size(), 32'd3);
    chk("rv_idle_psel", 32'(psel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
